// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM states, select codes,
// requester count and a one-hot helper.
package rr_mux_arbiter_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [1:0] SEL_A = 2'd0;
   localparam logic [1:0] SEL_B = 2'd1;
   localparam logic [1:0] SEL_C = 2'd2;
   localparam logic [1:0] SEL_D = 2'd3;

   function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester/output channel bundle of the arbiter. The arbiter uses the slave
// modport; the producer/consumer environment uses the master modport.
interface rr_mux_arbiter_if #(
   parameter int N = 4
);
   import rr_mux_arbiter_pkg::*;

   logic [NREQ-1:0] req;
   logic [N-1:0]    a;
   logic [N-1:0]    b;
   logic [N-1:0]    c;
   logic [N-1:0]    d;
   logic [NREQ-1:0] ack;
   logic [1:0]      sel;
   logic [N-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;

   modport slave (
      input  req, a, b, c, d, out_ready,
      output ack, sel, out_data, out_valid
   );

   modport master (
      output req, a, b, c, d, out_ready,
      input  ack, sel, out_data, out_valid
   );

endinterface

// File: rtl/rr_mux_arbiter_mux4.sv
// Plain 4:1 N-bit data mux steered by the arbitration winner.
module rr_mux4
   import rr_mux_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [1:0]   i_sel,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic [N-1:0] i_c,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_y
);

   always_comb begin
      o_y = i_a;
      case (i_sel)
         SEL_A:   o_y = i_a;
         SEL_B:   o_y = i_b;
         SEL_C:   o_y = i_c;
         SEL_D:   o_y = i_d;
         default: o_y = i_a;
      endcase
   end

endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin pick: first requester at or after i_ptr (wrapping 3->0).
module rr_pick
   import rr_mux_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] i_req,
   input  logic [1:0]      i_ptr,
   output logic [1:0]      o_win,
   output logic            o_found
);

   logic [NREQ-1:0] w_rot;

   // w_rot[k] is the request at distance k from the pointer; 2-bit index wraps naturally.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
         logic [1:0] w_idx;
         assign w_idx       = i_ptr + 2'(gi);
         assign w_rot[gi]   = i_req[w_idx];
      end
   endgenerate

   always_comb begin
      o_found = |w_rot;
      o_win   = i_ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            o_win = i_ptr + 2'(k);
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among four requesters.
// Optional burst mode (winner keeps priority up to MAX_BURST captures): define RR_ARB_BURST_EN.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int N         = 4,
   parameter int MAX_BURST = 4
) (
   input logic              clk,
   input logic              rst_n,
   rr_mux_arbiter_if.slave  io_bus
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

`ifdef RR_ARB_BURST_EN
   localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
`else
   localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(1);
`endif

   state_t           r_state;
   state_t           w_state_next;
   logic [1:0]       r_ptr;
   logic [1:0]       w_ptr_next;
   logic [1:0]       r_sel;
   logic [1:0]       w_sel_next;
   logic [N-1:0]     r_data;
   logic [N-1:0]     w_data_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [1:0]       w_win;
   logic             w_found;
   logic             w_cap;
   logic [N-1:0]     w_mux;
   logic [NREQ-1:0]  w_ack;

   rr_pick u_pick (
      .i_req   (io_bus.req),
      .i_ptr   (r_ptr),
      .o_win   (w_win),
      .o_found (w_found)
   );

   rr_mux4 #(.N(N)) u_mux (
      .i_sel (w_win),
      .i_a   (io_bus.a),
      .i_b   (io_bus.b),
      .i_c   (io_bus.c),
      .i_d   (io_bus.d),
      .o_y   (w_mux)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= 2'd0;
         r_sel   <= SEL_A;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ptr   <= w_ptr_next;
         r_sel   <= w_sel_next;
         r_data  <= w_data_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // In BUSY out_valid is 1, so a capture slot opens exactly when the held word is accepted.
   assign w_cap = (r_state == ST_IDLE) || io_bus.out_ready;

   // r_cnt != 0 means the previous capture belonged to the run of r_sel.
   assign w_cnt_inc = ((w_win == r_sel) && (r_cnt != '0)) ? r_cnt + CNT_W'(1) : CNT_W'(1);

   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      w_sel_next   = r_sel;
      w_data_next  = r_data;
      w_cnt_next   = r_cnt;
      w_ack        = '0;
      if (w_cap) begin
         if (w_found) begin
            w_ack        = onehot(w_win);
            w_state_next = ST_BUSY;
            w_sel_next   = w_win;
            w_data_next  = w_mux;
            if (w_cnt_inc >= BURST_LIMIT) begin
               w_ptr_next = w_win + 2'd1;
               w_cnt_next = '0;
            end else begin
               w_ptr_next = w_win;
               w_cnt_next = w_cnt_inc;
            end
         end else begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
         end
      end
   end

   assign io_bus.ack       = w_ack & {NREQ{rst_n}};
   assign io_bus.out_valid = (r_state == ST_BUSY);
   assign io_bus.sel       = r_sel;
   assign io_bus.out_data  = r_data;

endmodule
